wave_capture_mc: RTL and testbench

Multi-channel, triggered waveform capture engine. It is the parametrised successor to the single-channel lab capture block, with configurable sample width, depth and channel count, a selectable trigger channel and trigger mode.
- Writes one DEPTH-sample frame per trigger into the inactive half of a double-buffered display RAM.
- Flips read_index to hand the frame to the display when the display reports idle (vsync low).
- Sits between the codec sample stream and the display RAM write port.

---
 rtl/wave_capture_mc.sv | 213 +++++++++++++++++++++
 tb/tb_wave_capture_mc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_mc.sv
// wave_capture_mc: multi-channel triggered waveform capture into a double-buffered display RAM.
// Optional macro AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT strobes spent waiting in ARMED.
module wave_capture_mc #(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_W     = 16,
  parameter int DISP_W       = 8,
  parameter int DEPTH_LOG2   = 8,
  parameter int SEL_W        = 1,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_sample_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] new_sample_in,
  input  logic [SEL_W-1:0]           trig_sel,
  input  logic [1:0]                 mode,
  input  logic                       wave_display_idle,
  output logic [DEPTH_LOG2:0]        write_address,
  output logic                       write_enable,
  output logic [NUM_CH*DISP_W-1:0]   write_sample,
  output logic                       read_index,
  output logic                       armed,
  output logic                       capture_done
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] CNT_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST = {DEPTH_LOG2{1'b1}};

  if (DISP_W > SAMPLE_W) begin : g_bad_disp_w
    $error("wave_capture_mc: DISP_W must not exceed SAMPLE_W");
  end
  if ((1 << SEL_W) < NUM_CH) begin : g_bad_sel_w
    $error("wave_capture_mc: SEL_W too narrow for NUM_CH");
  end
  if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
    $error("wave_capture_mc: AUTO_TIMEOUT must be at least 1");
  end

  // Signed sample to offset-binary display code: keep the top DISP_W bits, flip the sign bit.
  function automatic logic [NUM_CH*DISP_W-1:0] to_display(input logic [NUM_CH*SAMPLE_W-1:0] s);
    logic [NUM_CH*DISP_W-1:0] d;
    d = {(NUM_CH*DISP_W){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      d[c*DISP_W +: DISP_W]   = s[c*SAMPLE_W + SAMPLE_W - DISP_W +: DISP_W];
      d[c*DISP_W + DISP_W-1]  = ~s[c*SAMPLE_W + SAMPLE_W-1];
    end
    return d;
  endfunction

  state_t                   state_r, nx_state_s;
  logic [DEPTH_LOG2-1:0]    count_r, nx_count_s;
  logic                     prev_trig_r, nx_prev_trig_s;
  logic                     read_index_r, nx_read_index_s;
  logic                     we_r, nx_we_s;
  logic                     done_r, nx_done_s;
  logic                     armed_r, nx_armed_s;
  logic [DEPTH_LOG2:0]      addr_r, nx_addr_s;
  logic [NUM_CH*DISP_W-1:0] sample_r, nx_sample_s;
  logic                     cur_msb_s;
  logic                     trig_hit_s;
  logic                     force_s;
  logic                     unused_bits_s;

  // Low sample bits below the display width never reach the RAM.
  assign unused_bits_s = ^new_sample_in;

  // Sign bit of the selected trigger channel; out-of-range selections fall back to channel 0.
  always_comb begin
    cur_msb_s = new_sample_in[SAMPLE_W-1];
    for (int c = 1; c < NUM_CH; c++) begin
      if (trig_sel == SEL_W'(c)) begin
        cur_msb_s = new_sample_in[c*SAMPLE_W + SAMPLE_W-1];
      end else begin
        cur_msb_s = cur_msb_s;
      end
    end
  end

  // Trigger condition per mode; mode 3 behaves as rising.
  always_comb begin
    trig_hit_s = 1'b0;
    case (mode)
      2'd0:    trig_hit_s = 1'b1;
      2'd2:    trig_hit_s = ~prev_trig_r & cur_msb_s;
      default: trig_hit_s = prev_trig_r & ~cur_msb_s;
    endcase
  end

`ifdef AUTO_TRIG_EN
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT) + 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
  logic [AUTO_W-1:0] auto_cnt_r;

  // Armed-strobe counter, held at zero outside ARMED so every arming starts a fresh timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if (state_r != ST_ARMED) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if (new_sample_ready) begin
      auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end

  assign force_s = (auto_cnt_r == AUTO_LAST);
`else
  assign force_s = 1'b0;
`endif

  // Next-state and next-output logic for the ARMED / ACTIVE / WAIT capture sequence.
  always_comb begin
    nx_state_s      = state_r;
    nx_count_s      = count_r;
    nx_prev_trig_s  = prev_trig_r;
    nx_read_index_s = read_index_r;
    nx_we_s         = 1'b0;
    nx_done_s       = 1'b0;
    nx_addr_s       = addr_r;
    nx_sample_s     = sample_r;

    if (new_sample_ready) begin
      nx_prev_trig_s = cur_msb_s;
    end else begin
      nx_prev_trig_s = prev_trig_r;
    end

    case (state_r)
      ST_ARMED: begin
        if (new_sample_ready && (trig_hit_s || force_s)) begin
          nx_we_s     = 1'b1;
          nx_addr_s   = {~read_index_r, CNT_ZERO};
          nx_sample_s = to_display(new_sample_in);
          nx_count_s  = CNT_ONE;
          nx_state_s  = ST_ACTIVE;
        end else begin
          nx_state_s  = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          nx_we_s     = 1'b1;
          nx_addr_s   = {~read_index_r, count_r};
          nx_sample_s = to_display(new_sample_in);
          if (count_r == CNT_LAST) begin
            nx_done_s  = 1'b1;
            nx_count_s = CNT_ZERO;
            nx_state_s = ST_WAIT;
          end else begin
            nx_count_s = count_r + CNT_ONE;
          end
        end else begin
          nx_state_s = ST_ACTIVE;
        end
      end
      ST_WAIT: begin
        if (wave_display_idle) begin
          nx_read_index_s = ~read_index_r;
          nx_state_s      = ST_ARMED;
        end else begin
          nx_state_s      = ST_WAIT;
        end
      end
      default: begin
        nx_state_s = ST_ARMED;
        nx_count_s = CNT_ZERO;
      end
    endcase

    nx_armed_s = (nx_state_s == ST_ARMED);
  end

  // State and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_ARMED;
      count_r      <= CNT_ZERO;
      prev_trig_r  <= 1'b0;
      read_index_r <= 1'b0;
      we_r         <= 1'b0;
      done_r       <= 1'b0;
      armed_r      <= 1'b1;
      addr_r       <= {(DEPTH_LOG2+1){1'b0}};
      sample_r     <= {(NUM_CH*DISP_W){1'b0}};
    end else begin
      state_r      <= nx_state_s;
      count_r      <= nx_count_s;
      prev_trig_r  <= nx_prev_trig_s;
      read_index_r <= nx_read_index_s;
      we_r         <= nx_we_s;
      done_r       <= nx_done_s;
      armed_r      <= nx_armed_s;
      addr_r       <= nx_addr_s;
      sample_r     <= nx_sample_s;
    end
  end

  assign write_address = addr_r;
  assign write_enable  = we_r;
  assign write_sample  = sample_r;
  assign read_index    = read_index_r;
  assign armed         = armed_r;
  assign capture_done  = done_r;

endmodule

// File: tb/tb_wave_capture_mc.sv
// Directed bench for wave_capture_mc with a frame-level reference model checked every cycle.
// Follows the AUTO_TRIG_EN macro of the design build.
module tb_wave_capture_mc;

  localparam int NUM_CH       = 2;
  localparam int SAMPLE_W     = 16;
  localparam int DISP_W       = 8;
  localparam int DEPTH_LOG2   = 8;
  localparam int SEL_W        = 1;
  localparam int AUTO_TIMEOUT = 1024;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int M_ARMED      = 0;
  localparam int M_CAPTURE    = 1;
  localparam int M_WAIT       = 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       new_sample_ready = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] new_sample_in = '0;
  logic [SEL_W-1:0]           trig_sel = '0;
  logic [1:0]                 mode = 2'd0;
  logic                       wave_display_idle = 1'b0;
  logic [DEPTH_LOG2:0]        write_address;
  logic                       write_enable;
  logic [NUM_CH*DISP_W-1:0]   write_sample;
  logic                       read_index;
  logic                       armed;
  logic                       capture_done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int   m_phase = M_ARMED;
  int   m_idx = 0;
  int   m_auto = 0;
  bit   m_prev_neg = 1'b0;
  bit   m_read_bank = 1'b0;
  logic exp_we = 1'b0;
  logic exp_done = 1'b0;
  logic [DEPTH_LOG2:0] exp_addr = '0;
  logic [NUM_CH*DISP_W-1:0] exp_sample = '0;

  wave_capture_mc #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DISP_W(DISP_W),
    .DEPTH_LOG2(DEPTH_LOG2), .SEL_W(SEL_W), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .trig_sel(trig_sel), .mode(mode),
    .wave_display_idle(wave_display_idle), .write_address(write_address),
    .write_enable(write_enable), .write_sample(write_sample),
    .read_index(read_index), .armed(armed), .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Display code as plain arithmetic: shift signed range to unsigned, keep the top byte.
  function automatic logic [NUM_CH*DISP_W-1:0] expect_disp(input logic [NUM_CH*SAMPLE_W-1:0] s);
    logic [NUM_CH*DISP_W-1:0] r;
    logic signed [SAMPLE_W-1:0] v;
    int u;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = s[c*SAMPLE_W +: SAMPLE_W];
      u = (int'(v) + 32768) / 256;
      r[c*DISP_W +: DISP_W] = 8'(u);
    end
    return r;
  endfunction

  task automatic record(input int idx);
    exp_we     = 1'b1;
    exp_addr   = {~m_read_bank, 8'(idx)};
    exp_sample = expect_disp(new_sample_in);
  endtask

  // Frame-level model: tracks phase, frame index and display bank from the behavioural rules.
  initial forever begin
    int tch;
    logic signed [SAMPLE_W-1:0] tv;
    bit neg;
    bit hit;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_phase = M_ARMED; m_idx = 0; m_auto = 0; m_prev_neg = 1'b0; m_read_bank = 1'b0;
      exp_we = 1'b0; exp_done = 1'b0; exp_addr = '0; exp_sample = '0;
    end else begin
      exp_we = 1'b0;
      exp_done = 1'b0;
      tch = (int'(trig_sel) < NUM_CH) ? int'(trig_sel) : 0;
      tv = new_sample_in[tch*SAMPLE_W +: SAMPLE_W];
      neg = (tv < 0);
      if (m_phase == M_WAIT) begin
        if (wave_display_idle) begin
          m_read_bank = ~m_read_bank;
          m_phase = M_ARMED;
          m_auto = 0;
        end
      end else if (new_sample_ready) begin
        if (m_phase == M_ARMED) begin
          m_auto++;
          if (mode == 2'd0) hit = 1'b1;
          else if (mode == 2'd2) hit = !m_prev_neg && neg;
          else hit = m_prev_neg && !neg;
`ifdef AUTO_TRIG_EN
          if (m_auto == AUTO_TIMEOUT) hit = 1'b1;
`endif
          if (hit) begin
            record(0);
            m_idx = 1;
            m_phase = M_CAPTURE;
            m_auto = 0;
          end
        end else begin
          record(m_idx);
          if (m_idx == DEPTH - 1) begin
            exp_done = 1'b1;
            m_idx = 0;
            m_phase = M_WAIT;
          end else begin
            m_idx++;
          end
        end
      end
      if (new_sample_ready) m_prev_neg = neg;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("write_enable", 64'(write_enable), 64'(exp_we));
    chk("capture_done", 64'(capture_done), 64'(exp_done));
    chk("read_index", 64'(read_index), 64'(m_read_bank));
    chk("armed", 64'(armed), 64'(m_phase == M_ARMED));
    if (exp_we) begin
      chk("write_address", 64'(write_address), 64'(exp_addr));
      chk("write_sample", 64'(write_sample), 64'(exp_sample));
    end
  end

  task automatic strobe(input int c0, input int c1);
    @(posedge clk); #2;
    new_sample_in = {16'(c1), 16'(c0)};
    new_sample_ready = 1'b1;
    @(posedge clk); #2;
    new_sample_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held with strobes
    mode = 2'd1;
    for (int i = 0; i < 4; i++) strobe(i*1000 - 1500, 7);
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_ri", 64'(read_index), 64'd0);
    chk("rst_armed", 64'(armed), 64'd1);
    @(posedge clk); #2; reset = 1'b1;
    for (int i = 0; i < 4; i++) strobe(300, 300);
    chk("no_trig_we", 64'(write_enable), 64'd0);

    // 2: rising trigger on ch0 and a full frame into bank 1
    strobe(-100, 0);
    strobe(-50, 0);
    strobe(10, 1234);
    chk("t2_first_we", 64'(write_enable), 64'd1);
    chk("t2_first_addr", 64'(write_address), 64'h100);
    chk("t2_first_ch0", 64'(write_sample[7:0]), 64'h80);
    chk("t2_first_ch1", 64'(write_sample[15:8]), 64'h84);
    for (int i = 1; i < DEPTH; i++) strobe(10 + 100*i, -20000 + 150*i);
    chk("t2_done", 64'(capture_done), 64'd1);
    chk("t2_last_addr", 64'(write_address), 64'h1FF);
    chk("t2_last_ch0", 64'(write_sample[7:0]), 64'hE3);

    // 3: display busy, strobes ignored in WAIT, then handover
    for (int i = 0; i < 250; i++) strobe((i % 2 == 1) ? -7 : 7, 0);
    chk("t3_ri_held", 64'(read_index), 64'd0);
    chk("t3_not_armed", 64'(armed), 64'd0);
    trig_sel = 1'b1;
    mode = 2'd2;
    @(posedge clk); #2; wave_display_idle = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_flip", 64'(read_index), 64'd1);
    chk("t3_rearmed", 64'(armed), 64'd1);

    // 4: falling trigger on ch1 while ch0 rises
    strobe(-5, 5);
    strobe(5, 5);
    chk("t4_ch0_rise_ignored", 64'(write_enable), 64'd0);
    strobe(5, -5);
    chk("t4_we", 64'(write_enable), 64'd1);
    chk("t4_addr", 64'(write_address), 64'h000);
    chk("t4_sample", 64'(write_sample), 64'h7F80);

    // 5: reset after 100 writes, then restart in bank 1
    for (int i = 1; i < 100; i++) strobe(i, -i);
    @(posedge clk); #2; reset = 1'b0;
    #1;
    chk("t5_we", 64'(write_enable), 64'd0);
    chk("t5_addr", 64'(write_address), 64'd0);
    chk("t5_sample", 64'(write_sample), 64'd0);
    chk("t5_ri", 64'(read_index), 64'd0);
    chk("t5_armed", 64'(armed), 64'd1);
    @(posedge clk); #2; reset = 1'b1;
    mode = 2'd1;
    trig_sel = 1'b0;
    strobe(-1, 0);
    strobe(1000, 0);
    chk("t5_restart_addr", 64'(write_address), 64'h100);
    for (int i = 1; i < DEPTH; i++) strobe(1000 + 37*i, 200*i - 25000);
    chk("t5_done", 64'(capture_done), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t5_flip", 64'(read_index), 64'd1);

    // 6: constant positive input in rising mode
`ifdef AUTO_TRIG_EN
    for (int i = 0; i < AUTO_TIMEOUT - 1; i++) strobe(1, 1);
    chk("t6_before_timeout", 64'(write_enable), 64'd0);
    strobe(1, 1);
    chk("t6_forced_we", 64'(write_enable), 64'd1);
    chk("t6_forced_addr", 64'(write_address), 64'h000);
`else
    for (int i = 0; i < 5000; i++) strobe(1, 1);
    chk("t6_still_armed", 64'(armed), 64'd1);
    chk("t6_no_write", 64'(write_enable), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
